// File: rtl/ex_commit_stage_pkg.sv
// Shared encodings for the commit stage: instruction type codes, FSM states and
// condition-code bit positions.
package ex_commit_stage_pkg;

    localparam logic [2:0] R_TYPE = 3'd0;
    localparam logic [2:0] I_TYPE = 3'd1;
    localparam logic [2:0] B_TYPE = 3'd2;
    localparam logic [2:0] J_TYPE = 3'd3;

    localparam int CC_BR = 0;
    localparam int CC_OV = 1;
    localparam int CC_UF = 2;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_SQUASH    = 2'd1,
        ST_TRAP_WAIT = 2'd2
    } state_e;

    function automatic logic is_alu_type(input logic [2:0] t);
        return (t == R_TYPE) || (t == I_TYPE);
    endfunction

endpackage

// File: rtl/ex_skid_buf.sv
// Two-entry valid/ready skid buffer. Entry 0 is the head and drives the outputs;
// o_full_next lets the producer register its ready one cycle ahead.
module ex_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_full_next,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic [W-1:0] r_data [2];
    logic [W-1:0] w_data_next [2];
    logic [1:0]   r_count;
    logic [1:0]   w_count_mid;
    logic [1:0]   w_count_next;
    logic         w_pop;
    logic         w_push;

    assign w_pop  = (r_count != 2'd0) && i_ready;
    assign w_push = i_valid && ((r_count != 2'd2) || w_pop);

    always_comb begin
        w_data_next[0] = r_data[0];
        w_data_next[1] = r_data[1];
        w_count_mid    = r_count;
        if (w_pop) begin
            w_data_next[0] = r_data[1];
            w_count_mid    = r_count - 2'd1;
        end
        w_count_next = w_count_mid;
        if (w_push) begin
            // Popping first means the free slot is always at index w_count_mid.
            if (w_count_mid == 2'd0) begin
                w_data_next[0] = i_data;
            end else begin
                w_data_next[1] = i_data;
            end
            w_count_next = w_count_mid + 2'd1;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_data[gi] <= '0;
            end else begin
                r_data[gi] <= w_data_next[gi];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign o_full_next = (w_count_next == 2'd2);
    assign o_valid     = (r_count != 2'd0);
    assign o_data      = r_data[0];

endmodule

// File: rtl/ex_commit_stage.sv
// Commit stage after the ALU: resolves branch/jump redirects, tracks sticky
// overflow/underflow with an optional overflow trap, and forwards results via a skid buffer.
module ex_commit_stage
    import ex_commit_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [DATA_W-1:0] in_alu_out,
    input  logic [3:0]        in_alu_cc,
    input  logic [DATA_W-1:0] in_br_target,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_wb_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_wb_en,
    output logic              redirect_valid,
    output logic [DATA_W-1:0] redirect_pc,
    output logic              trap_valid,
    output logic [DATA_W-1:0] trap_pc,
    input  logic              trap_ack,
    input  logic              trap_en,
    output logic [3:0]        status,
    input  logic              status_clr
);

    localparam int PAY_W = DATA_W + REG_AW + 1;

    state_e            r_state;
    state_e            w_state_next;
    logic              r_in_ready;
    logic              r_redirect_valid;
    logic [DATA_W-1:0] r_redirect_pc;
    logic              r_trap_valid;
    logic [DATA_W-1:0] r_trap_pc;
    logic [1:0]        r_sticky;
    logic [1:0]        w_sticky_next;

    logic [2:0]        w_type;
    logic              w_accept;
    logic              w_push;
    logic              w_redirect;
    logic              w_trap;
    logic [DATA_W-1:0] w_redirect_pc;
    logic [DATA_W-1:0] w_result;
    logic              w_wb_en;
    logic              w_full_next;
    logic [PAY_W-1:0]  w_push_data;
    logic [PAY_W-1:0]  w_out_data;
    logic              w_unused_bits;

    assign w_type        = in_opcode[2:0];
    assign w_accept      = in_valid && r_in_ready;
    assign w_unused_bits = &{1'b0, in_opcode[6:3], in_alu_cc[3]};

    always_comb begin
        w_state_next  = r_state;
        w_push        = 1'b0;
        w_redirect    = 1'b0;
        w_trap        = 1'b0;
        w_redirect_pc = in_alu_out;
        w_result      = in_alu_out;
        w_wb_en       = in_wb_en;
        // Clear first, then OR in new flags, so a same-cycle set survives the clear.
        w_sticky_next = status_clr ? 2'b00 : r_sticky;
        case (r_state)
            ST_RUN: begin
                if (w_accept) begin
                    if (w_type == B_TYPE) begin
                        if (in_alu_cc[CC_BR]) begin
                            w_redirect    = 1'b1;
                            w_redirect_pc = in_br_target;
                            w_state_next  = ST_SQUASH;
                        end
                    end else begin
                        w_push = 1'b1;
                        if (w_type == J_TYPE) begin
                            w_result = in_pc + DATA_W'(4);
                            if (in_alu_cc[CC_BR]) begin
                                w_redirect   = 1'b1;
                                w_state_next = ST_SQUASH;
                            end
                        end else if (is_alu_type(w_type)) begin
                            w_sticky_next[0] = w_sticky_next[0] | in_alu_cc[CC_OV];
                            w_sticky_next[1] = w_sticky_next[1] | in_alu_cc[CC_UF];
                            if (in_alu_cc[CC_OV] && trap_en) begin
                                w_trap       = 1'b1;
                                w_wb_en      = 1'b0;
                                w_state_next = ST_TRAP_WAIT;
                            end
                        end
                    end
                end
            end
            ST_SQUASH: begin
                w_state_next = ST_RUN;
            end
            ST_TRAP_WAIT: begin
                if (trap_ack) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_RUN;
            r_in_ready       <= 1'b1;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_trap_valid     <= 1'b0;
            r_trap_pc        <= '0;
            r_sticky         <= 2'b00;
        end else begin
            r_state          <= w_state_next;
            // The squash cycle swallows its beat, so it may accept even with a full buffer.
            r_in_ready       <= (w_state_next == ST_SQUASH) ||
                                ((w_state_next == ST_RUN) && !w_full_next);
            r_redirect_valid <= w_redirect;
            if (w_redirect) begin
                r_redirect_pc <= w_redirect_pc;
            end
            r_trap_valid     <= (w_state_next == ST_TRAP_WAIT);
            if (w_trap) begin
                r_trap_pc <= in_pc;
            end
            r_sticky         <= w_sticky_next;
        end
    end

    assign w_push_data = {w_wb_en, in_rd, w_result};

    ex_skid_buf #(
        .W(PAY_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (w_push),
        .i_data      (w_push_data),
        .o_full_next (w_full_next),
        .o_valid     (out_valid),
        .i_ready     (out_ready),
        .o_data      (w_out_data)
    );

    assign out_result     = w_out_data[DATA_W-1:0];
    assign out_rd         = w_out_data[DATA_W +: REG_AW];
    assign out_wb_en      = w_out_data[PAY_W-1];
    assign in_ready       = r_in_ready;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign trap_valid     = r_trap_valid;
    assign trap_pc        = r_trap_pc;
    assign status         = {1'b0, r_sticky[1], r_sticky[0], 1'b0};

endmodule
